// File: rtl/vote_collector.sv
// Sequential ballot loader: packs one N-bit vote per voter into a sealed ballot.
// Optional macro VOTE_COLLECTOR_DUP_REJECT_EN discards re-votes and pulses dup_err.
module vote_collector #(
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vote_valid,
  output logic                   vote_ready,
  input  logic [M-1:0]           vote_id,
  input  logic [N-1:0]           vote_val,
  input  logic                   close,
  output logic                   ballot_valid,
  input  logic                   ballot_ready,
  output logic [(2**M)*N-1:0]    ballot,
  output logic [2**M-1:0]        voted_mask,
  output logic [M:0]             vote_count,
  output logic                   dup_err
);

  localparam int S  = 2**M;
  localparam int BW = S*N;
  localparam logic [M:0] FULL = (M+1)'(S);
  localparam logic [M:0] ONE  = (M+1)'(1);

  typedef enum logic {
    COLLECT,
    SEALED
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] ballot_q, ballot_d;
  logic [S-1:0]  mask_q, mask_d;
  logic [M:0]    count_q, count_d;
  logic          dup_d;
  logic          accept;

  assign accept = vote_valid && (state_q == COLLECT);

  always_comb begin
    state_d  = state_q;
    ballot_d = ballot_q;
    mask_d   = mask_q;
    count_d  = count_q;
    dup_d    = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          if (!mask_q[vote_id]) begin
            ballot_d[int'(vote_id)*N +: N] = vote_val;
            mask_d[vote_id] = 1'b1;
            count_d = count_q + ONE;
          end else begin
`ifdef VOTE_COLLECTOR_DUP_REJECT_EN
            dup_d = 1'b1;
`else
            ballot_d[int'(vote_id)*N +: N] = vote_val;
`endif
          end
        end
        // A vote arriving with close is written before the seal.
        if (close || count_d == FULL)
          state_d = SEALED;
      end
      SEALED: begin
        if (ballot_ready) begin
          state_d  = COLLECT;
          ballot_d = '0;
          mask_d   = '0;
          count_d  = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      ballot_q <= '0;
      mask_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ballot_q <= ballot_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
    end
  end

`ifdef VOTE_COLLECTOR_DUP_REJECT_EN
  logic dup_q;
  always_ff @(posedge clk) begin
    if (!rst_n) dup_q <= 1'b0;
    else        dup_q <= dup_d;
  end
  assign dup_err = dup_q;
`else
  assign dup_err = 1'b0;
`endif

  assign vote_ready   = (state_q == COLLECT);
  assign ballot_valid = (state_q == SEALED);
  assign ballot       = ballot_q;
  assign voted_mask   = mask_q;
  assign vote_count   = count_q;

endmodule

// File: tb/tb_vote_collector.sv
// Directed self-checking bench for vote_collector (N=2, M=2).
// Expectations follow VOTE_COLLECTOR_DUP_REJECT_EN when defined.
module tb_vote_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vote_valid;
  logic       vote_ready;
  logic [1:0] vote_id;
  logic [1:0] vote_val;
  logic       close;
  logic       ballot_valid;
  logic       ballot_ready;
  logic [7:0] ballot;
  logic [3:0] voted_mask;
  logic [2:0] vote_count;
  logic       dup_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vote_collector #(.N(2), .M(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vote_valid   (vote_valid),
    .vote_ready   (vote_ready),
    .vote_id      (vote_id),
    .vote_val     (vote_val),
    .close        (close),
    .ballot_valid (ballot_valid),
    .ballot_ready (ballot_ready),
    .ballot       (ballot),
    .voted_mask   (voted_mask),
    .vote_count   (vote_count),
    .dup_err      (dup_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] id, input logic [1:0] val);
    vote_valid = 1'b1;
    vote_id    = id;
    vote_val   = val;
    tick();
    vote_valid = 1'b0;
  endtask

  task automatic release_ballot();
    ballot_ready = 1'b1;
    tick();
    ballot_ready = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] b,
                           input logic [3:0] m, input logic [2:0] c,
                           input logic bv);
    chk({tag, "_ballot"}, 32'(ballot), 32'(b));
    chk({tag, "_mask"},   32'(voted_mask), 32'(m));
    chk({tag, "_count"},  32'(vote_count), 32'(c));
    chk({tag, "_bvalid"}, 32'(ballot_valid), 32'(bv));
    chk({tag, "_vready"}, 32'(vote_ready), 32'(!bv));
  endtask

  initial begin
    rst_n = 1'b0; vote_valid = 1'b0; vote_id = '0; vote_val = '0;
    close = 1'b0; ballot_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk_state("reset", 8'h00, 4'h0, 3'd0, 1'b0);
    chk("reset_dup", 32'(dup_err), 32'd0);

    send(2'd0, 2'd1);
    chk_state("v1", 8'h01, 4'h1, 3'd1, 1'b0);
    send(2'd1, 2'd2); send(2'd2, 2'd3); send(2'd3, 2'd0);
    chk_state("full", 8'h39, 4'hF, 3'd4, 1'b1);

    vote_valid = 1'b1; vote_id = 2'd0; vote_val = 2'd3; close = 1'b1;
    repeat (5) tick();
    vote_valid = 1'b0; close = 1'b0;
    chk_state("hold", 8'h39, 4'hF, 3'd4, 1'b1);
    release_ballot();
    chk_state("rel1", 8'h00, 4'h0, 3'd0, 1'b0);

    send(2'd1, 2'd3); send(2'd2, 2'd2);
    close = 1'b1; tick(); close = 1'b0;
    chk_state("close", 8'h2C, 4'h6, 3'd2, 1'b1);
    release_ballot();

    send(2'd1, 2'd3); send(2'd2, 2'd2);
    close = 1'b1; send(2'd3, 2'd1); close = 1'b0;
    chk_state("close_vote", 8'h6C, 4'hE, 3'd3, 1'b1);
    release_ballot();

    ballot_ready = 1'b1;
    send(2'd0, 2'd1);
    ballot_ready = 1'b0;
    chk_state("rdy_collect", 8'h01, 4'h1, 3'd1, 1'b0);
    chk("dup_first", 32'(dup_err), 32'd0);
    send(2'd0, 2'd2);
`ifdef VOTE_COLLECTOR_DUP_REJECT_EN
    chk_state("dup", 8'h01, 4'h1, 3'd1, 1'b0);
    chk("dup_pulse", 32'(dup_err), 32'd1);
`else
    chk_state("dup", 8'h02, 4'h1, 3'd1, 1'b0);
    chk("dup_pulse", 32'(dup_err), 32'd0);
`endif
    tick();
    chk("dup_clear", 32'(dup_err), 32'd0);
    close = 1'b1; tick(); close = 1'b0;
    release_ballot();

    send(2'd0, 2'd1); send(2'd1, 2'd1); send(2'd2, 2'd1);
    chk_state("pre_rst", 8'h15, 4'h7, 3'd3, 1'b0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk_state("mid_rst", 8'h00, 4'h0, 3'd0, 1'b0);
    send(2'd3, 2'd3); send(2'd2, 2'd2); send(2'd1, 2'd1);
    chk_state("post_rst3", 8'hE4, 4'hE, 3'd3, 1'b0);
    send(2'd0, 2'd0);
    chk_state("post_rst4", 8'hE4, 4'hF, 3'd4, 1'b1);

    close = 1'b1; tick(); close = 1'b0;
    chk_state("sealed_close", 8'hE4, 4'hF, 3'd4, 1'b1);
    release_ballot();

    close = 1'b1; tick(); close = 1'b0;
    chk_state("empty", 8'h00, 4'h0, 3'd0, 1'b1);
    release_ballot();
    chk_state("end", 8'h00, 4'h0, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
